// File: rtl/dspm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dspm_arb_pkg
// Shared definitions for the data scratchpad (DSpm) port arbiter:
//   - DSpm geometry (4096 x 32-bit words, 4 byte strobes)
//   - arbiter state encoding
//   - bus holding-register layout
// No ports (package).
// -----------------------------------------------------------------------------
package dspm_arb_pkg;

    localparam int DSPM_ADDR_W = 12;
    localparam int DSPM_DATA_W = 32;
    localparam int DSPM_BYTES  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [DSPM_ADDR_W-1:0] addr;
        logic [DSPM_BYTES-1:0]  byte_write;
        logic [DSPM_DATA_W-1:0] data;
        logic                   is_read;
    } hold_req_t;

endpackage

// File: rtl/dspm_starve_counter.sv
// -----------------------------------------------------------------------------
// dspm_starve_counter
// Saturating count of cycles in which a held bus request was refused because
// the core owned the port. When the count reaches LIMIT while a request is
// still held, force_grant takes the port away from the core for one cycle.
//
// Ports:
//   clk          in   clock
//   reset_n      in   asynchronous active-low reset
//   pending      in   bus request held in the arbiter
//   core_enable  in   core access requested this cycle
//   issue        in   bus request issued this cycle (clears the count)
//   force_grant  out  count has reached LIMIT with a request held
// -----------------------------------------------------------------------------
module dspm_starve_counter
    import dspm_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pending,
    input  logic core_enable,
    input  logic issue,
    output logic force_grant
);

    localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (issue) begin
            count <= '0;
        end else if (pending && core_enable && (count != LIMIT_C)) begin
            count <= count + 1'b1;
        end
    end

    assign force_grant = pending && (count == LIMIT_C);

endmodule

// File: rtl/dspm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dspm_port_arbiter
// Shares the single DSpm port between the core memory stage (fixed latency,
// highest priority) and a bus master. A bus request is captured in a one-entry
// holding register and issued in a cycle the core leaves idle; the completion
// pulse (bus_resp_valid) follows the issue cycle by one cycle, carrying read
// data straight from the DSpm output.
//
// Optional feature (compile-time macro DSPM_ARB_STARVE_GUARD_EN):
//   a starvation counter forces a bus grant after STARVE_LIMIT refused cycles,
//   stalling the core for that one cycle. Without the macro core_stall is 0
//   and a continuously busy core can hold the bus off indefinitely.
//
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   core_addr/enable/byte_write/data_in core request (byte_write==0 -> read)
//   core_data_out                      core read data (DSpm output)
//   core_stall                         core access refused, hold request
//   bus_valid/ready                    bus request handshake
//   bus_addr/byte_write/data_in        bus request (byte_write==0 -> read)
//   bus_resp_valid                     one-cycle completion pulse
//   bus_data_out                       bus read data while bus_resp_valid
//   mem_addr/enable/byte_write/data_in DSpm port drive
//   mem_data_out                       DSpm read data (1-cycle latency)
// -----------------------------------------------------------------------------
module dspm_port_arbiter
    import dspm_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,

    input  logic [DSPM_ADDR_W-1:0] core_addr,
    input  logic                   core_enable,
    input  logic [DSPM_BYTES-1:0]  core_byte_write,
    input  logic [DSPM_DATA_W-1:0] core_data_in,
    output logic [DSPM_DATA_W-1:0] core_data_out,
    output logic                   core_stall,

    input  logic                   bus_valid,
    output logic                   bus_ready,
    input  logic [DSPM_ADDR_W-1:0] bus_addr,
    input  logic [DSPM_BYTES-1:0]  bus_byte_write,
    input  logic [DSPM_DATA_W-1:0] bus_data_in,
    output logic                   bus_resp_valid,
    output logic [DSPM_DATA_W-1:0] bus_data_out,

    output logic [DSPM_ADDR_W-1:0] mem_addr,
    output logic                   mem_enable,
    output logic [DSPM_BYTES-1:0]  mem_byte_write,
    output logic [DSPM_DATA_W-1:0] mem_data_in,
    input  logic [DSPM_DATA_W-1:0] mem_data_out
);

    arb_state_t state;
    arb_state_t state_next;
    hold_req_t  hold;
    logic       accept;
    logic       issue;
    logic       force_grant;
    logic       resp_vld_p1;

    // A full holding register refuses new requests, so accept (IDLE only)
    // and issue (PEND only) can never coincide.
    assign bus_ready = (state == IDLE);
    assign accept    = bus_valid && bus_ready;
    assign issue     = (state == PEND) && (!core_enable || force_grant);

`ifdef DSPM_ARB_STARVE_GUARD_EN
    dspm_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_counter (
        .clk         (clk),
        .reset_n     (reset_n),
        .pending     (state == PEND),
        .core_enable (core_enable),
        .issue       (issue),
        .force_grant (force_grant)
    );

    assign core_stall = force_grant && core_enable;
`else
    assign force_grant = 1'b0;
    assign core_stall  = 1'b0;

    wire unused_starve_limit = (STARVE_LIMIT != 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            resp_vld_p1 <= 1'b0;
        end else begin
            state       <= state_next;
            resp_vld_p1 <= issue;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = PEND;
            PEND: if (issue)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Holding register payload carries no reset: it is only observed
    // while the state register says PEND.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold <= '{addr:       bus_addr,
                      byte_write: bus_byte_write,
                      data:       bus_data_in,
                      is_read:    (bus_byte_write == '0)};
        end
    end

    // Stage p0: DSpm port mux, bus issue overrides the core.
    always_comb begin
        mem_addr       = core_addr;
        mem_enable     = core_enable;
        mem_byte_write = core_byte_write;
        mem_data_in    = core_data_in;
        if (issue) begin
            mem_addr       = hold.addr;
            mem_enable     = 1'b1;
            mem_byte_write = hold.is_read ? '0 : hold.byte_write;
            mem_data_in    = hold.data;
        end
    end

    // Stage p1: DSpm read data returns; the bus response pulse lines up with it.
    assign bus_resp_valid = resp_vld_p1;
    assign bus_data_out   = mem_data_out;
    assign core_data_out  = mem_data_out;

endmodule

// File: tb/tb_dspm_port_arbiter.sv
`timescale 1ns/1ps
module tb_dspm_port_arbiter;

    localparam int unsigned LIMIT = 3;
`ifdef DSPM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] core_addr;
    logic        core_enable;
    logic [3:0]  core_byte_write;
    logic [31:0] core_data_in;
    logic [31:0] core_data_out;
    logic        core_stall;
    logic        bus_valid;
    logic        bus_ready;
    logic [11:0] bus_addr;
    logic [3:0]  bus_byte_write;
    logic [31:0] bus_data_in;
    logic        bus_resp_valid;
    logic [31:0] bus_data_out;
    logic [11:0] mem_addr;
    logic        mem_enable;
    logic [3:0]  mem_byte_write;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    int errors = 0;
    int checks = 0;

    dspm_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .core_addr(core_addr), .core_enable(core_enable),
        .core_byte_write(core_byte_write), .core_data_in(core_data_in),
        .core_data_out(core_data_out), .core_stall(core_stall),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_byte_write(bus_byte_write), .bus_data_in(bus_data_in),
        .bus_resp_valid(bus_resp_valid), .bus_data_out(bus_data_out),
        .mem_addr(mem_addr), .mem_enable(mem_enable),
        .mem_byte_write(mem_byte_write), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // DSpm stand-in: 4096 x 32, byte strobes, 1-cycle read latency.
    logic [31:0] dspm [0:4095];
    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_byte_write == 4'h0) begin
                mem_data_out <= dspm[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_byte_write[b]) dspm[mem_addr][8*b +: 8] <= mem_data_in[8*b +: 8];
            end
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        core_enable = 1'b0; core_addr = 12'h0; core_byte_write = 4'h0; core_data_in = 32'h0;
        bus_valid = 1'b0; bus_addr = 12'h0; bus_byte_write = 4'h0; bus_data_in = 32'h0;
    endtask

    task automatic test_reset();
        idle_in();
        reset_n = 1'b0;
        core_enable = 1'b1; core_addr = 12'h0AB;
        #2;
        checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL reset_bus_ready: got %b expected 1", bus_ready); end
        checks++; if (bus_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp: got %b expected 0", bus_resp_valid); end
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", core_stall); end
        checks++; if (mem_enable !== 1'b1 || mem_addr !== 12'h0AB) begin errors++; $display("FAIL reset_mem_follow: got en=%b addr=%h expected en=1 addr=0ab", mem_enable, mem_addr); end
        core_enable = 1'b0;
        #1;
        checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL reset_mem_idle: got %b expected 0", mem_enable); end
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_bus_write_idle();
        idle_in();
        bus_valid = 1'b1; bus_addr = 12'h010; bus_byte_write = 4'hF; bus_data_in = 32'hDEADBEEF;
        #1;
        checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL wr_accept_ready: got %b expected 1", bus_ready); end
        cyc();
        bus_valid = 1'b0;
        #1;
        checks++; if (mem_enable !== 1'b1 || mem_addr !== 12'h010 || mem_byte_write !== 4'hF || mem_data_in !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_issue: got en=%b addr=%h be=%h d=%h expected en=1 addr=010 be=f d=deadbeef", mem_enable, mem_addr, mem_byte_write, mem_data_in); end
        checks++; if (bus_resp_valid !== 1'b0) begin errors++; $display("FAIL wr_resp_early: got %b expected 0", bus_resp_valid); end
        cyc();
        #1;
        checks++; if (bus_resp_valid !== 1'b1) begin errors++; $display("FAIL wr_resp: got %b expected 1", bus_resp_valid); end
        checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_after: got %b expected 1", bus_ready); end
        cyc();
        core_enable = 1'b1; core_addr = 12'h010;
        #1;
        checks++; if (bus_resp_valid !== 1'b0) begin errors++; $display("FAIL wr_resp_single: got %b expected 0", bus_resp_valid); end
        cyc();
        core_enable = 1'b0;
        #1;
        checks++; if (core_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_core_readback: got %h expected deadbeef", core_data_out); end
    endtask

    task automatic test_bus_read_core_busy();
        int exp_k;
        exp_k = GUARD ? int'(LIMIT) + 1 : 6;
        idle_in();
        core_enable = 1'b1; core_addr = 12'h030;
        bus_valid = 1'b1; bus_addr = 12'h010; bus_byte_write = 4'h0;
        #1;
        checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL rd_accept_ready: got %b expected 1", bus_ready); end
        for (int k = 1; k <= 7; k++) begin
            cyc();
            bus_valid = 1'b0;
            core_enable = (k <= 5);
            #1;
            checks++; if (bus_ready !== (k > exp_k)) begin errors++; $display("FAIL rd_busy_ready k=%0d: got %b expected %b", k, bus_ready, (k > exp_k)); end
            checks++; if (mem_enable !== ((k == exp_k) || (k <= 5))) begin errors++; $display("FAIL rd_busy_en k=%0d: got %b", k, mem_enable); end
            if (k == exp_k) begin
                checks++; if (mem_addr !== 12'h010 || mem_byte_write !== 4'h0) begin errors++; $display("FAIL rd_busy_issue k=%0d: got addr=%h be=%h expected addr=010 be=0", k, mem_addr, mem_byte_write); end
            end else if (k <= 5) begin
                checks++; if (mem_addr !== 12'h030) begin errors++; $display("FAIL rd_busy_core k=%0d: got addr=%h expected 030", k, mem_addr); end
            end
            checks++; if (bus_resp_valid !== (k == exp_k + 1)) begin errors++; $display("FAIL rd_busy_resp k=%0d: got %b expected %b", k, bus_resp_valid, (k == exp_k + 1)); end
            if (k == exp_k + 1) begin
                checks++; if (bus_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_busy_data: got %h expected deadbeef", bus_data_out); end
            end
        end
    endtask

    task automatic test_partial_write();
        idle_in();
        cyc();
        core_enable = 1'b1; core_addr = 12'h040; core_byte_write = 4'hF; core_data_in = 32'h11223344;
        cyc();
        idle_in();
        bus_valid = 1'b1; bus_addr = 12'h040; bus_byte_write = 4'h2; bus_data_in = 32'h0000AB00;
        cyc();
        bus_valid = 1'b0;
        #1;
        checks++; if (mem_byte_write !== 4'h2 || mem_addr !== 12'h040) begin errors++; $display("FAIL pw_issue: got be=%h addr=%h expected be=2 addr=040", mem_byte_write, mem_addr); end
        cyc();
        #1;
        checks++; if (bus_resp_valid !== 1'b1) begin errors++; $display("FAIL pw_resp: got %b expected 1", bus_resp_valid); end
        core_enable = 1'b1; core_addr = 12'h040;
        cyc();
        core_enable = 1'b0;
        #1;
        checks++; if (core_data_out !== 32'h1122AB44) begin errors++; $display("FAIL pw_readback: got %h expected 1122ab44", core_data_out); end
    endtask

    task automatic test_reset_pending();
        idle_in();
        cyc();
        core_enable = 1'b1; core_addr = 12'h060; core_byte_write = 4'hF; core_data_in = 32'h0;
        cyc();
        core_byte_write = 4'h0; core_addr = 12'h050;
        bus_valid = 1'b1; bus_addr = 12'h060; bus_byte_write = 4'hF; bus_data_in = 32'hCAFEF00D;
        cyc();
        bus_valid = 1'b0;
        #1;
        checks++; if (bus_ready !== 1'b0) begin errors++; $display("FAIL rp_pending: got %b expected 0", bus_ready); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL rp_async_clear: got %b expected 1", bus_ready); end
        cyc();
        reset_n = 1'b1;
        core_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++; if (bus_ready !== 1'b1 || bus_resp_valid !== 1'b0 || mem_enable !== 1'b0) begin
                errors++; $display("FAIL rp_dropped k=%0d: got ready=%b resp=%b en=%b expected 1 0 0", k, bus_ready, bus_resp_valid, mem_enable); end
        end
        core_enable = 1'b1; core_addr = 12'h060;
        cyc();
        core_enable = 1'b0;
        #1;
        checks++; if (core_data_out !== 32'h0) begin errors++; $display("FAIL rp_no_write: got %h expected 00000000", core_data_out); end
        // response pulse cut short by reset
        bus_valid = 1'b1; bus_addr = 12'h010; bus_byte_write = 4'h0;
        cyc();
        bus_valid = 1'b0;
        cyc();
        checks++; if (bus_resp_valid !== 1'b1) begin errors++; $display("FAIL rp_resp_before: got %b expected 1", bus_resp_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus_resp_valid !== 1'b0) begin errors++; $display("FAIL rp_resp_suppressed: got %b expected 0", bus_resp_valid); end
        cyc();
        reset_n = 1'b1;
        cyc();
        checks++; if (bus_resp_valid !== 1'b0) begin errors++; $display("FAIL rp_resp_after: got %b expected 0", bus_resp_valid); end
    endtask

    task automatic test_starve();
        idle_in();
        cyc();
        core_enable = 1'b1; core_addr = 12'h070;
        bus_valid = 1'b1; bus_addr = 12'h080; bus_byte_write = 4'hF; bus_data_in = 32'h12345678;
        #1;
        checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL sv_accept: got %b expected 1", bus_ready); end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            bus_valid = 1'b0;
            #1;
`ifdef DSPM_ARB_STARVE_GUARD_EN
            checks++; if (core_stall !== (k == 4)) begin errors++; $display("FAIL sv_stall k=%0d: got %b expected %b", k, core_stall, (k == 4)); end
            checks++; if (mem_addr !== ((k == 4) ? 12'h080 : 12'h070)) begin errors++; $display("FAIL sv_addr k=%0d: got %h", k, mem_addr); end
            checks++; if (bus_resp_valid !== (k == 5)) begin errors++; $display("FAIL sv_resp k=%0d: got %b expected %b", k, bus_resp_valid, (k == 5)); end
`else
            checks++; if (core_stall !== 1'b0 || bus_ready !== 1'b0 || bus_resp_valid !== 1'b0 || mem_addr !== 12'h070) begin
                errors++; $display("FAIL sv_noguard k=%0d: got stall=%b ready=%b resp=%b addr=%h expected 0 0 0 070", k, core_stall, bus_ready, bus_resp_valid, mem_addr); end
`endif
        end
        core_enable = 1'b0;
        #1;
`ifndef DSPM_ARB_STARVE_GUARD_EN
        checks++; if (mem_enable !== 1'b1 || mem_addr !== 12'h080 || mem_data_in !== 32'h12345678) begin
            errors++; $display("FAIL sv_drain: got en=%b addr=%h d=%h expected 1 080 12345678", mem_enable, mem_addr, mem_data_in); end
`endif
        cyc();
        cyc();
    endtask

    task automatic test_random();
        logic [31:0] shadow [0:15];
        bit          m_pend, m_resp, m_resp_read, m_core_due, m_stall_prev;
        bit          exp_force, exp_issue, exp_stall;
        logic [11:0] r_addr;
        logic [3:0]  r_be;
        logic [31:0] r_data, m_resp_data, m_core_data;
        int unsigned m_cnt;
        idle_in();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            core_enable = 1'b1; core_addr = 12'h100 + 12'(i); core_byte_write = 4'hF;
            core_data_in = $urandom; shadow[i] = core_data_in;
        end
        m_pend = 0; m_resp = 0; m_resp_read = 0; m_core_due = 0; m_stall_prev = 0; m_cnt = 0;
        r_addr = '0; r_be = '0; r_data = '0; m_resp_data = '0; m_core_data = '0;
        for (int n = 0; n < 600; n++) begin
            cyc();
            if (!m_stall_prev) begin
                core_enable = ($urandom_range(0, 99) < 65);
                core_addr = {8'h10, 4'($urandom_range(0, 15))};
                core_byte_write = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
                core_data_in = $urandom;
            end
            bus_valid = $urandom_range(0, 1);
            bus_addr = {8'h10, 4'($urandom_range(0, 15))};
            bus_byte_write = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
            bus_data_in = $urandom;
            #1;
            exp_force = GUARD && m_pend && (m_cnt == LIMIT);
            exp_issue = m_pend && (!core_enable || exp_force);
            exp_stall = exp_force && core_enable;
            checks++; if (bus_ready !== !m_pend) begin errors++; $display("FAIL rnd_ready n=%0d: got %b expected %b", n, bus_ready, !m_pend); end
            checks++; if (core_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall n=%0d: got %b expected %b", n, core_stall, exp_stall); end
            checks++; if (bus_resp_valid !== m_resp) begin errors++; $display("FAIL rnd_resp n=%0d: got %b expected %b", n, bus_resp_valid, m_resp); end
            checks++; if (mem_enable !== (exp_issue || core_enable)) begin errors++; $display("FAIL rnd_mem_en n=%0d: got %b expected %b", n, mem_enable, (exp_issue || core_enable)); end
            if (m_resp && m_resp_read) begin
                checks++; if (bus_data_out !== m_resp_data) begin errors++; $display("FAIL rnd_bus_data n=%0d: got %h expected %h", n, bus_data_out, m_resp_data); end
            end
            if (m_core_due) begin
                checks++; if (core_data_out !== m_core_data) begin errors++; $display("FAIL rnd_core_data n=%0d: got %h expected %h", n, core_data_out, m_core_data); end
            end
            if (exp_issue) begin
                checks++; if (mem_addr !== r_addr || mem_byte_write !== r_be || (r_be != 0 && mem_data_in !== r_data)) begin
                    errors++; $display("FAIL rnd_bus_issue n=%0d: got addr=%h be=%h d=%h expected addr=%h be=%h d=%h", n, mem_addr, mem_byte_write, mem_data_in, r_addr, r_be, r_data); end
            end else if (core_enable) begin
                checks++; if (mem_addr !== core_addr || mem_byte_write !== core_byte_write || (core_byte_write != 0 && mem_data_in !== core_data_in)) begin
                    errors++; $display("FAIL rnd_core_pass n=%0d: got addr=%h be=%h expected addr=%h be=%h", n, mem_addr, mem_byte_write, core_addr, core_byte_write); end
            end
            // advance the reference model across the coming clock edge
            m_resp = exp_issue;
            m_resp_read = (r_be == 4'h0);
            m_resp_data = shadow[r_addr[3:0]];
            m_core_due = core_enable && !exp_stall && (core_byte_write == 4'h0);
            m_core_data = shadow[core_addr[3:0]];
            if (exp_issue && r_be != 4'h0)
                shadow[r_addr[3:0]] = merge(shadow[r_addr[3:0]], r_be, r_data);
            else if (!exp_issue && core_enable && core_byte_write != 4'h0)
                shadow[core_addr[3:0]] = merge(shadow[core_addr[3:0]], core_byte_write, core_data_in);
            if (exp_issue) m_cnt = 0;
            else if (m_pend && core_enable && m_cnt < LIMIT) m_cnt++;
            m_stall_prev = exp_stall;
            if (exp_issue) begin
                m_pend = 0;
            end else if (!m_pend && bus_valid) begin
                m_pend = 1; r_addr = bus_addr; r_be = bus_byte_write; r_data = bus_data_in;
            end
        end
        idle_in();
        cyc(); cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_bus_write_idle();
        test_bus_read_core_busy();
        test_partial_write();
        test_reset_pending();
        test_starve();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
